// File: rtl/bp_cce_dir_lru_seq.sv
// bp_cce_dir_lru_seq
// Sequences one directory-RAM read per CCE LRU query. A query (way-group, LCE,
// LRU way) is mapped to the RAM row holding that LCE's tag set. The block then
// arbitrates for the shared directory RAM port and captures the row one cycle
// after the grant. It extracts the coherence state and tag of the LRU way and
// returns them as a registered result.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   req_v_i / req_ready_o       query handshake; accepted when both are high
//   req_wg_i, req_lce_i,
//   req_way_i                   query fields, latched on accept
//   ram_v_o / ram_gnt_i         RAM read request / grant (read issued on grant)
//   ram_addr_o                  row address (zero when not requesting)
//   ram_row_i                   read data, valid the cycle after the grant
//   dir_w_v_i, dir_w_addr_i     directory write by another agent
//   lru_v_o / lru_yumi_i        result handshake; consumer takes on yumi
//   lru_cached_excl_o           LRU entry is in M or E
//   lru_tag_o                   LRU entry tag
//   dbg_state_o                 current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// (or yumi) are both high. valid never depends on ready/yumi in the same cycle.
// A query that arrives while the block is busy is dropped, not queued. A yumi
// that arrives with no result pending is ignored.
//
// Optional feature macro: BP_CCE_LRU_SEQ_REREAD_EN. When it is defined, a
// directory write to the row being read forces a re-read. The write can fall
// in the grant cycle or in the data cycle.

`ifndef BP_CCE_COH_BITS
`define BP_CCE_COH_BITS 3
`endif
`ifndef BP_CCE_COH_SHARED_BIT
`define BP_CCE_COH_SHARED_BIT 0
`endif

module bp_cce_dir_lru_seq #(
  parameter int num_wg_p           = 64,
  parameter int rows_per_wg_p      = 2,
  parameter int tag_sets_per_row_p = 2,
  parameter int num_lce_p          = 4,
  parameter int lce_assoc_p        = 8,
  parameter int tag_width_p        = 10,
  parameter int row_width_p        = tag_sets_per_row_p*lce_assoc_p*(tag_width_p+`BP_CCE_COH_BITS),
  localparam int wg_w     = (num_wg_p > 1) ? $clog2(num_wg_p) : 1,
  localparam int lce_w    = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  localparam int way_w    = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int addr_w   = (num_wg_p*rows_per_wg_p > 1) ? $clog2(num_wg_p*rows_per_wg_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   req_v_i,
  output logic                   req_ready_o,
  input  logic [wg_w-1:0]        req_wg_i,
  input  logic [lce_w-1:0]       req_lce_i,
  input  logic [way_w-1:0]       req_way_i,
  output logic                   ram_v_o,
  input  logic                   ram_gnt_i,
  output logic [addr_w-1:0]      ram_addr_o,
  input  logic [row_width_p-1:0] ram_row_i,
  input  logic                   dir_w_v_i,
  input  logic [addr_w-1:0]      dir_w_addr_i,
  output logic                   lru_v_o,
  input  logic                   lru_yumi_i,
  output logic                   lru_cached_excl_o,
  output logic [tag_width_p-1:0] lru_tag_o,
  output logic [1:0]             dbg_state_o
);

  localparam int coh_w     = `BP_CCE_COH_BITS;
  localparam int entry_w   = tag_width_p + coh_w;
  localparam int row_bits  = (rows_per_wg_p > 1) ? $clog2(rows_per_wg_p) : 0;
  localparam int set_bits  = (tag_sets_per_row_p > 1) ? $clog2(tag_sets_per_row_p) : 0;
  localparam int set_w     = (set_bits > 0) ? set_bits : 1;
  localparam int row_idx_w = (row_width_p > 1) ? $clog2(row_width_p) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_e;

  state_e                 state_q, state_d;
  logic [addr_w-1:0]      addr_q, addr_d;
  logic [set_w-1:0]       set_q, set_d;
  logic [way_w-1:0]       way_q, way_d;
  logic [tag_width_p-1:0] tag_q, tag_d;
  logic                   excl_q, excl_d;

  // Row mapping. Rows per way-group is a power of two, so
  // wg*rows_per_wg_p + row_in_wg is just the concatenation {wg, row_in_wg}.
  logic [addr_w-1:0] req_addr;
  logic [set_w-1:0]  req_set;

  if (rows_per_wg_p == 1) begin : g_one_row
    assign req_addr = addr_w'(req_wg_i);
  end else begin : g_multi_row
    assign req_addr = addr_w'({req_wg_i, req_lce_i[set_bits +: row_bits]});
  end

  if (tag_sets_per_row_p == 1) begin : g_one_set
    assign req_set = '0;
  end else begin : g_multi_set
    assign req_set = set_w'(req_lce_i[set_bits-1:0]);
  end

  // Entry extraction. Each entry is {tag, state}, laid out [set][way] with
  // set 0 / way 0 at the LSB.
  logic [row_idx_w-1:0]   bit_idx;
  logic [entry_w-1:0]     entry;
  logic [coh_w-1:0]       entry_state;
  logic [tag_width_p-1:0] entry_tag;
  logic                   entry_excl;

  assign bit_idx     = row_idx_w'((int'(set_q)*lce_assoc_p + int'(way_q))*entry_w);
  assign entry       = ram_row_i[bit_idx +: entry_w];
  assign entry_state = entry[coh_w-1:0];
  assign entry_tag   = entry[coh_w +: tag_width_p];
  // The NONE state (all zero) falls out as non-exclusive through the OR-reduce.
  assign entry_excl  = (|entry_state) & ~entry_state[`BP_CCE_COH_SHARED_BIT];

`ifdef BP_CCE_LRU_SEQ_REREAD_EN
  logic reread_q, reread_d;
  logic wr_hit;
  assign wr_hit = dir_w_v_i && (dir_w_addr_i == addr_q);
`else
  logic unused_dir_w;
  assign unused_dir_w = &{1'b0, dir_w_v_i, dir_w_addr_i};
`endif

  // State register (also holds the latched request and the registered result)
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      set_q    <= '0;
      way_q    <= '0;
      tag_q    <= '0;
      excl_q   <= 1'b0;
`ifdef BP_CCE_LRU_SEQ_REREAD_EN
      reread_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      set_q    <= set_d;
      way_q    <= way_d;
      tag_q    <= tag_d;
      excl_q   <= excl_d;
`ifdef BP_CCE_LRU_SEQ_REREAD_EN
      reread_q <= reread_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    set_d    = set_q;
    way_d    = way_q;
    tag_d    = tag_q;
    excl_d   = excl_q;
`ifdef BP_CCE_LRU_SEQ_REREAD_EN
    reread_d = reread_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_v_i) begin
          addr_d  = req_addr;
          set_d   = req_set;
          way_d   = req_way_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ram_gnt_i) begin
          state_d  = S_WAIT;
`ifdef BP_CCE_LRU_SEQ_REREAD_EN
          // A write landing in the grant cycle makes the returned row stale.
          reread_d = wr_hit;
`endif
        end
      end
      S_WAIT: begin
`ifdef BP_CCE_LRU_SEQ_REREAD_EN
        if (reread_q || wr_hit) begin
          reread_d = 1'b0;
          state_d  = S_REQ;
        end else begin
          tag_d   = entry_tag;
          excl_d  = entry_excl;
          state_d = S_DONE;
        end
`else
        tag_d   = entry_tag;
        excl_d  = entry_excl;
        state_d = S_DONE;
`endif
      end
      S_DONE: begin
        if (lru_yumi_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready_o       = (state_q == S_IDLE);
    ram_v_o           = (state_q == S_REQ);
    ram_addr_o        = (state_q == S_REQ) ? addr_q : '0;
    lru_v_o           = (state_q == S_DONE);
    lru_cached_excl_o = excl_q;
    lru_tag_o         = tag_q;
    dbg_state_o       = state_q;
  end

endmodule
